// File: rtl/lms_train_ctrl.sv
// Sequencing controller for a 3-tap LMS adaptive FIR: clears, fills and trains the
// filter, declares convergence from a windowed mean |err|, and re-trains on degradation.
module lms_train_ctrl #(
  parameter int                 NB_DATA   = 16,
  parameter int                 NB_CNT    = 12,
  parameter int                 TRAIN_LEN = 512,
  parameter int                 TIMEOUT   = 4000,
  parameter int                 WIN_LOG2  = 4,
  parameter logic [NB_DATA-1:0] ERR_THR   = 16'd328,
  parameter int                 NB_RETRY  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic                       i_valid,
  input  logic signed [NB_DATA-1:0]  i_err,
  output logic                       o_smp_en,
  output logic                       o_adapt_en,
  output logic                       o_coef_clr,
  output logic                       o_converged,
  output logic                       o_timeout,
  output logic [2:0]                 o_state,
  output logic [NB_DATA-1:0]         o_err_avg,
  output logic [NB_RETRY-1:0]        o_retrain_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
    S_TRAIN = 3'd3,
    S_TRACK = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam int                NB_ACC      = NB_DATA + WIN_LOG2;
  localparam logic [NB_CNT-1:0] L_TRAIN_LEN = NB_CNT'(TRAIN_LEN);
  localparam logic [NB_CNT-1:0] L_TIMEOUT   = NB_CNT'(TIMEOUT);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_fill_cnt;
  logic [NB_CNT-1:0]     r_train_cnt;
  logic [NB_CNT-1:0]     w_train_inc;
  logic                  r_err_vld;
  logic [NB_ACC-1:0]     r_acc;
  logic [NB_ACC-1:0]     w_acc_sum;
  logic [WIN_LOG2-1:0]   r_win_cnt;
  logic [NB_DATA-1:0]    r_err_avg;
  logic                  r_timeout;
  logic [NB_RETRY-1:0]   r_retrain_cnt;
  logic [NB_DATA-1:0]    w_err_mag;
  logic [NB_DATA-1:0]    w_avg;
  logic                  w_smp;
  logic                  w_consume;
  logic                  w_win_done;
  logic                  w_change;
  logic                  w_start_ok;
  logic                  w_timeout_hit;
  logic                  w_converge;
  logic                  w_degrade;

  // |err| with the most negative code saturated so it stays representable
  always_comb begin
    if (i_err == {1'b1, {(NB_DATA-1){1'b0}}})
      w_err_mag = {1'b0, {(NB_DATA-1){1'b1}}};
    else if (i_err[NB_DATA-1])
      w_err_mag = -i_err;
    else
      w_err_mag = i_err;
  end

  assign w_smp         = i_valid & ((r_state == S_FILL) | (r_state == S_TRAIN) | (r_state == S_TRACK));
  assign w_consume     = r_err_vld & ((r_state == S_TRAIN) | (r_state == S_TRACK));
  assign w_acc_sum     = r_acc + {{WIN_LOG2{1'b0}}, w_err_mag};
  assign w_avg         = w_acc_sum[NB_ACC-1:WIN_LOG2];
  assign w_win_done    = w_consume & (&r_win_cnt);
  assign w_train_inc   = (&r_train_cnt) ? r_train_cnt : r_train_cnt + 1'b1;
  assign w_timeout_hit = w_smp & (r_state == S_TRAIN) & (w_train_inc >= L_TIMEOUT);
  assign w_converge    = w_win_done & (r_train_cnt >= L_TRAIN_LEN) & (w_avg < ERR_THR);
  assign w_degrade     = w_win_done & (w_avg >= ERR_THR);
  assign w_change      = (w_state_nxt != r_state);
  assign w_start_ok    = i_start & ~i_stop & ((r_state == S_IDLE) | (r_state == S_FAULT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Convergence is checked before timeout so it wins a same-cycle tie
  always_comb begin
    w_state_nxt = r_state;
    if (i_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_state_nxt = S_CLEAR;
        S_CLEAR: w_state_nxt = S_FILL;
        S_FILL:  if (w_smp && (r_fill_cnt == 2'd2)) w_state_nxt = S_TRAIN;
        S_TRAIN: begin
          if (w_converge)         w_state_nxt = S_TRACK;
          else if (w_timeout_hit) w_state_nxt = S_FAULT;
        end
        S_TRACK: if (w_degrade) w_state_nxt = S_TRAIN;
        S_FAULT: if (i_start) w_state_nxt = S_CLEAR;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_smp_en      = w_smp;
    o_adapt_en    = (r_state == S_TRAIN);
    o_coef_clr    = (r_state == S_CLEAR);
    o_converged   = (r_state == S_TRACK);
    o_state       = r_state;
    o_timeout     = r_timeout;
    o_err_avg     = r_err_avg;
    o_retrain_cnt = r_retrain_cnt;
  end

  // An error belongs to the state that accepted its sample; a state change drops it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_vld     <= 1'b0;
      r_fill_cnt    <= '0;
      r_train_cnt   <= '0;
      r_acc         <= '0;
      r_win_cnt     <= '0;
      r_err_avg     <= '0;
      r_timeout     <= 1'b0;
      r_retrain_cnt <= '0;
    end else begin
      r_err_vld <= w_smp & ~w_change;

      if (w_change || i_stop) begin
        r_fill_cnt  <= '0;
        r_train_cnt <= '0;
      end else begin
        if ((r_state == S_FILL) && w_smp)  r_fill_cnt  <= r_fill_cnt + 2'd1;
        if ((r_state == S_TRAIN) && w_smp) r_train_cnt <= w_train_inc;
      end

      if (w_change || i_stop || w_win_done) begin
        r_acc     <= '0;
        r_win_cnt <= '0;
      end else if (w_consume) begin
        r_acc     <= w_acc_sum;
        r_win_cnt <= r_win_cnt + 1'b1;
      end

      if (w_win_done && !i_stop) r_err_avg <= w_avg;

      if (w_start_ok) begin
        r_timeout     <= 1'b0;
        r_retrain_cnt <= '0;
      end else begin
        if ((r_state == S_TRAIN) && (w_state_nxt == S_FAULT)) r_timeout <= 1'b1;
        if ((r_state == S_TRACK) && (w_state_nxt == S_TRAIN) && !(&r_retrain_cnt))
          r_retrain_cnt <= r_retrain_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lms_train_ctrl.sv
// Bench for lms_train_ctrl: directed scenarios plus a randomized run, checked every
// cycle against a rule-level reference model of the training sequence.
module tb_lms_train_ctrl;

  localparam int IDLE = 0, CLEAR = 1, FILL = 2, TRAIN = 3, TRACK = 4, FAULT = 5;
  localparam int TRAIN_LEN = 32, TIMEOUT = 64, WIN = 4, THR = 100;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_start, i_stop, i_valid;
  logic signed [15:0] i_err;
  logic               o_smp_en, o_adapt_en, o_coef_clr, o_converged, o_timeout;
  logic [2:0]         o_state;
  logic [15:0]        o_err_avg;
  logic [7:0]         o_retrain_cnt;

  lms_train_ctrl #(
    .NB_DATA(16), .NB_CNT(12), .TRAIN_LEN(TRAIN_LEN), .TIMEOUT(TIMEOUT),
    .WIN_LOG2(2), .ERR_THR(16'd100), .NB_RETRY(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_valid(i_valid), .i_err(i_err), .o_smp_en(o_smp_en), .o_adapt_en(o_adapt_en),
    .o_coef_clr(o_coef_clr), .o_converged(o_converged), .o_timeout(o_timeout),
    .o_state(o_state), .o_err_avg(o_err_avg), .o_retrain_cnt(o_retrain_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model
  int m_state, m_fill, m_train, m_avg, m_retrain;
  bit m_timeout, m_pend;
  int m_win[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag(input int e);
    if (e == -32768) return 32767;
    return (e < 0) ? -e : e;
  endfunction

  task automatic m_reset();
    m_state = IDLE; m_fill = 0; m_train = 0; m_avg = 0; m_retrain = 0;
    m_timeout = 0; m_pend = 0;
    m_win.delete();
  endtask

  task automatic model_step(input bit v, input bit st, input bit sp, input int e, input bit smp);
    int nxt, avg, s;
    bit done, chg;
    done = 0; avg = 0;
    if (m_pend && (m_state == TRAIN || m_state == TRACK)) begin
      m_win.push_back(mag(e));
      if (m_win.size() == WIN) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        avg = s / WIN;
        done = 1;
      end
    end
    nxt = m_state;
    if (sp) nxt = IDLE;
    else case (m_state)
      IDLE:  if (st) nxt = CLEAR;
      CLEAR: nxt = FILL;
      FILL:  if (smp && m_fill == 2) nxt = TRAIN;
      TRAIN: begin
        if (done && m_train >= TRAIN_LEN && avg < THR) nxt = TRACK;
        else if (smp && m_train + 1 >= TIMEOUT)        nxt = FAULT;
      end
      TRACK: if (done && avg >= THR) nxt = TRAIN;
      FAULT: if (st) nxt = CLEAR;
      default: nxt = IDLE;
    endcase
    chg = (nxt != m_state);
    if (!sp && st && (m_state == IDLE || m_state == FAULT)) begin
      m_timeout = 0;
      m_retrain = 0;
    end
    if (m_state == TRAIN && nxt == FAULT) m_timeout = 1;
    if (m_state == TRACK && nxt == TRAIN && m_retrain < 255) m_retrain++;
    if (done && !sp) m_avg = avg;
    if (done || chg || sp) m_win.delete();
    if (chg || sp) begin
      m_fill = 0;
      m_train = 0;
    end else begin
      if (m_state == FILL && smp) m_fill++;
      if (m_state == TRAIN && smp && m_train < 4095) m_train++;
    end
    m_pend = smp && !chg;
    m_state = nxt;
  endtask

  task automatic chk_all();
    chk("state", o_state, m_state);
    chk("adapt_en", o_adapt_en, m_state == TRAIN);
    chk("coef_clr", o_coef_clr, m_state == CLEAR);
    chk("converged", o_converged, m_state == TRACK);
    chk("timeout", o_timeout, m_timeout);
    chk("err_avg", o_err_avg, m_avg);
    chk("retrain_cnt", o_retrain_cnt, m_retrain);
  endtask

  // One clock: drive, check the combinational enable, step the model, check registers
  task automatic cyc(input bit v, input bit st, input bit sp, input int e);
    bit smp;
    i_valid = v; i_start = st; i_stop = sp; i_err = 16'(e);
    #2;
    smp = v && (m_state == FILL || m_state == TRAIN || m_state == TRACK);
    chk("smp_en", o_smp_en, smp);
    model_step(v, st, sp, e, smp);
    @(posedge i_clk); #1;
    i_start = 0; i_stop = 0;
    chk_all();
  endtask

  initial begin
    int k, n_clr, r, e;
    i_rst = 1; i_start = 0; i_stop = 0; i_valid = 0; i_err = '0;
    m_reset();
    @(posedge i_clk); #1;
    chk("rst_smp_en", o_smp_en, 0);
    chk_all();
    i_rst = 0;

    // basic convergence: sample every 2nd cycle, err = +50
    n_clr = 0;
    cyc(0, 1, 0, 0);
    if (o_coef_clr) n_clr++;
    k = 0;
    while (m_state != TRACK && k < 400) begin
      cyc(k % 2 == 0, 0, 0, 50);
      if (o_coef_clr) n_clr++;
      k++;
    end
    chk("conv_clr_pulses", n_clr, 1);
    chk("conv_state", o_state, 4);
    chk("conv_converged", o_converged, 1);
    chk("conv_adapt", o_adapt_en, 0);
    chk("conv_avg", o_err_avg, 50);

    // retrain on degraded tracking error
    k = 0;
    while (m_state != TRAIN && k < 20) begin
      cyc(1, 0, 0, -200);
      k++;
    end
    chk("retrain_avg", o_err_avg, 200);
    chk("retrain_state", o_state, 3);
    chk("retrain_adapt", o_adapt_en, 1);
    chk("retrain_cnt1", o_retrain_cnt, 1);

    // most negative error saturates in the magnitude
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, -32768);
    chk("sat_avg", o_err_avg, 32767);

    // training timeout
    k = 0;
    while (m_state != FAULT && k < 100) begin
      cyc(1, 0, 0, 500);
      k++;
    end
    chk("to_state", o_state, 5);
    chk("to_flag", o_timeout, 1);
    cyc(1, 0, 0, 500);
    chk("to_smp_blocked", o_smp_en, 0);
    cyc(0, 1, 0, 0);
    chk("to_restart_state", o_state, 1);
    chk("to_restart_flag", o_timeout, 0);

    // randomized run around the threshold with rare start/stop
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      e = (r == 0) ? -32768 : int'($urandom_range(0, 360)) - 180;
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0, $urandom_range(0, 149) == 0, e);
    end

    // start and stop together in TRAIN
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    k = 0;
    while (m_state != TRAIN && k < 20) begin
      cyc(1, 0, 0, 20);
      k++;
    end
    cyc(1, 0, 0, 20);
    cyc(0, 1, 1, 0);
    chk("coll_state", o_state, 0);
    chk("coll_clr", o_coef_clr, 0);
    cyc(0, 0, 0, 0);
    chk("coll_clr_after", o_coef_clr, 0);

    // asynchronous reset between edges mid-TRAIN
    cyc(0, 1, 0, 0);
    k = 0;
    while (m_state != TRAIN && k < 20) begin
      cyc(1, 0, 0, 30);
      k++;
    end
    cyc(1, 0, 0, 30);
    i_valid = 1;
    #2;
    i_rst = 1;
    #1;
    m_reset();
    chk("arst_smp_en", o_smp_en, 0);
    chk_all();
    #1;
    i_rst = 0;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 30);
    chk("arst_idle", o_state, 0);
    cyc(0, 1, 0, 0);
    chk("arst_restart", o_state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
